// File: rtl/approx_adder_arbiter.sv
// approx_adder_arbiter: round-robin front end sharing one combinational
// approximate adder among N requesters, with a valid/ready response channel.
// Optional macro ERROR_MONITOR_EN adds an exact-reference error monitor;
// without it err_abs, err_nz_cnt and op_cnt are tied to zero.
module approx_adder_arbiter #(
    parameter int unsigned W    = 26,
    parameter int unsigned N    = 4,
    parameter int unsigned IDW  = 2,
    parameter int unsigned CNTW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [N*W-1:0]    req_in1,
    input  logic [N*W-1:0]    req_in2,
    input  logic [N-1:0]      req_add_sub,
    output logic [W-1:0]      add_in1,
    output logic [W-1:0]      add_in2,
    output logic              add_add_sub,
    input  logic [W:0]        add_res,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W:0]        rsp_res,
    output logic [W:0]        err_abs,
    output logic [CNTW-1:0]   err_nz_cnt,
    output logic [CNTW-1:0]   op_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  gnt_q, gnt_d;
    logic [W-1:0]    add_in1_q, add_in1_d;
    logic [W-1:0]    add_in2_q, add_in2_d;
    logic            add_sub_q, add_sub_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [W:0]      rsp_res_q, rsp_res_d;

    logic            found_c;
    logic [IDW-1:0]  gnt_idx_c;
    int unsigned     scan_idx;
    logic [N-1:0]    valid_sh;
    logic [W-1:0]    sel_in1_c;
    logic [W-1:0]    sel_in2_c;
    logic [N-1:0]    sel_sub_sh;

    // Round-robin scan: first pending requester at or after the pointer.
    always_comb begin
        found_c   = 1'b0;
        gnt_idx_c = '0;
        scan_idx  = 0;
        valid_sh  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            scan_idx = 32'(ptr_q) + k;
            if (scan_idx >= N) begin
                scan_idx = scan_idx - N;
            end
            valid_sh = req_valid >> scan_idx;
            if (!found_c && valid_sh[0]) begin
                found_c   = 1'b1;
                gnt_idx_c = IDW'(scan_idx);
            end
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        sel_in1_c  = W'(req_in1 >> (32'(gnt_idx_c) * W));
        sel_in2_c  = W'(req_in2 >> (32'(gnt_idx_c) * W));
        sel_sub_sh = req_add_sub >> gnt_idx_c;
    end

    // Next-state and grant logic; grants only issue from IDLE.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        add_in1_d   = add_in1_q;
        add_in2_d   = add_in2_q;
        add_sub_d   = add_sub_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_res_d   = rsp_res_q;
        req_ready   = '0;
        case (state_q)
            S_IDLE: begin
                if (found_c && !rst) begin
                    req_ready = N'(1) << gnt_idx_c;
                    gnt_d     = gnt_idx_c;
                    add_in1_d = sel_in1_c;
                    add_in2_d = sel_in2_c;
                    add_sub_d = sel_sub_sh[0];
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_res_d   = add_res;
                rsp_id_d    = gnt_q;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ptr_d       = (gnt_q == IDW'(N - 1)) ? '0 : gnt_q + IDW'(1);
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            add_in1_q   <= '0;
            add_in2_q   <= '0;
            add_sub_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_res_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            add_in1_q   <= add_in1_d;
            add_in2_q   <= add_in2_d;
            add_sub_q   <= add_sub_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_res_q   <= rsp_res_d;
        end
    end

    assign add_in1     = add_in1_q;
    assign add_in2     = add_in2_q;
    assign add_add_sub = add_sub_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_res     = rsp_res_q;

`ifdef ERROR_MONITOR_EN
    logic [W:0]      exact_c;
    logic [W:0]      err_abs_q, err_abs_d;
    logic [CNTW-1:0] op_cnt_q, op_cnt_d;
    logic [CNTW-1:0] err_nz_cnt_q, err_nz_cnt_d;

    // Exact reference, absolute error and saturating counters.
    always_comb begin
        exact_c      = add_sub_q ? ({1'b0, add_in1_q} - {1'b0, add_in2_q})
                                 : ({1'b0, add_in1_q} + {1'b0, add_in2_q});
        err_abs_d    = err_abs_q;
        op_cnt_d     = op_cnt_q;
        err_nz_cnt_d = err_nz_cnt_q;
        if (state_q == S_EXEC) begin
            err_abs_d = (add_res >= exact_c) ? (add_res - exact_c) : (exact_c - add_res);
        end
        if (state_q == S_RESP && rsp_ready) begin
            if (op_cnt_q != '1) begin
                op_cnt_d = op_cnt_q + CNTW'(1);
            end
            if (err_abs_q != '0 && err_nz_cnt_q != '1) begin
                err_nz_cnt_d = err_nz_cnt_q + CNTW'(1);
            end
        end
    end

    // Monitor registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_abs_q    <= '0;
            op_cnt_q     <= '0;
            err_nz_cnt_q <= '0;
        end else begin
            err_abs_q    <= err_abs_d;
            op_cnt_q     <= op_cnt_d;
            err_nz_cnt_q <= err_nz_cnt_d;
        end
    end

    assign err_abs    = err_abs_q;
    assign op_cnt     = op_cnt_q;
    assign err_nz_cnt = err_nz_cnt_q;
`else
    assign err_abs    = '0;
    assign op_cnt     = '0;
    assign err_nz_cnt = '0;
`endif

endmodule

// File: tb/tb_approx_adder_arbiter.sv
// Directed self-checking bench for approx_adder_arbiter.
module tb_approx_adder_arbiter;

    localparam int unsigned W   = 26;
    localparam int unsigned N   = 4;
    localparam int unsigned IDW = 2;
`ifdef ERROR_MONITOR_EN
    localparam int unsigned CNTW = 2;
    localparam int unsigned EXP_ERR = 4;
`else
    localparam int unsigned CNTW = 32;
    localparam int unsigned EXP_ERR = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*W-1:0]    req_in1;
    logic [N*W-1:0]    req_in2;
    logic [N-1:0]      req_add_sub;
    logic [W-1:0]      add_in1;
    logic [W-1:0]      add_in2;
    logic              add_add_sub;
    logic [W:0]        add_res;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W:0]        rsp_res;
    logic [W:0]        err_abs;
    logic [CNTW-1:0]   err_nz_cnt;
    logic [CNTW-1:0]   op_cnt;

    logic [W:0]        add_err;
    int                checks = 0;
    int                errors = 0;
    int                nacc   = 0;

    approx_adder_arbiter #(.W(W), .N(N), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in1(req_in1), .req_in2(req_in2), .req_add_sub(req_add_sub),
        .add_in1(add_in1), .add_in2(add_in2), .add_add_sub(add_add_sub),
        .add_res(add_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_res(rsp_res),
        .err_abs(err_abs), .err_nz_cnt(err_nz_cnt), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    // Approximate adder model: exact result plus a fixed error offset.
    always_comb begin
        add_res = (add_add_sub ? ({1'b0, add_in1} - {1'b0, add_in2})
                               : ({1'b0, add_in1} + {1'b0, add_in2})) + add_err;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ops(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sub);
        req_in1[idx*W +: W] = a;
        req_in2[idx*W +: W] = b;
        req_add_sub[idx]    = sub;
    endtask

    function automatic logic [63:0] exp_cnt(input int n);
`ifdef ERROR_MONITOR_EN
        return (n > 3) ? 64'd3 : 64'(n);
`else
        return (n > 0) ? 64'd0 : 64'd0;
`endif
    endfunction

    task automatic check_mon(input string tag);
        check({tag, "_err_abs"}, 64'(err_abs), 64'(EXP_ERR));
        check({tag, "_op_cnt"}, 64'(op_cnt), exp_cnt(nacc));
        check({tag, "_nz_cnt"}, 64'(err_nz_cnt), exp_cnt(nacc));
    endtask

    initial begin
        logic [N-1:0] exp_gnt;
        logic [W:0]   exp_res;
        int           id;

        rst = 1'b1; req_valid = '0; req_in1 = '0; req_in2 = '0; req_add_sub = '0;
        rsp_ready = 1'b0; add_err = (W+1)'(EXP_ERR);

        // Reset state.
        tick(); tick();
        check("rst_ready", 64'(req_ready), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rsp_id", 64'(rsp_id), 64'h0);
        check("rst_rsp_res", 64'(rsp_res), 64'h0);
        check("rst_add_in1", 64'(add_in1), 64'h0);
        check("rst_add_in2", 64'(add_in2), 64'h0);
        check("rst_add_sub", 64'(add_add_sub), 64'h0);
        check("rst_err_abs", 64'(err_abs), 64'h0);
        check("rst_op_cnt", 64'(op_cnt), 64'h0);
        check("rst_nz_cnt", 64'(err_nz_cnt), 64'h0);
        rst = 1'b0; nacc = 0;

        // Single request: 5 + 3.
        set_ops(0, 26'h5, 26'h3, 1'b0);
        req_valid = 4'b0001;
        #1 check("single_gnt", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        #1 check("single_exec_ready", 64'(req_ready), 64'h0);
        check("single_add_in1", 64'(add_in1), 64'h5);
        check("single_add_in2", 64'(add_in2), 64'h3);
        check("single_exec_valid", 64'(rsp_valid), 64'h0);
        tick();
        check("single_valid", 64'(rsp_valid), 64'h1);
        check("single_id", 64'(rsp_id), 64'h0);
        check("single_res", 64'(rsp_res), 64'h8 + 64'(EXP_ERR));
        rsp_ready = 1'b1;
        tick(); nacc++;
        check("single_drop", 64'(rsp_valid), 64'h0);

        // Fresh reset so round robin starts at requester 0.
        rst = 1'b1; tick(); rst = 1'b0; nacc = 0;

        // All four held valid: grants 0,1,2,3,0, one result every 3 cycles.
        set_ops(0, 26'h100, 26'h1, 1'b0);
        set_ops(1, 26'h200, 26'h2, 1'b0);
        set_ops(2, 26'h300, 26'h3, 1'b0);
        set_ops(3, 26'h400, 26'h4, 1'b0);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int op = 0; op < 5; op++) begin
            id = op % 4;
            exp_gnt = 4'b0001 << id;
            exp_res = (W+1)'(32'h101 * (id + 1) + EXP_ERR);
            #1 check("rr_gnt", 64'(req_ready), 64'(exp_gnt));
            tick();
            check("rr_exec_valid", 64'(rsp_valid), 64'h0);
            check("rr_exec_ready", 64'(req_ready), 64'h0);
            tick();
            check("rr_valid", 64'(rsp_valid), 64'h1);
            check("rr_id", 64'(rsp_id), 64'(id));
            check("rr_res", 64'(rsp_res), 64'(exp_res));
            tick(); nacc++;
            check("rr_drop", 64'(rsp_valid), 64'h0);
        end

        // Backpressure: pointer is now 1.
        rsp_ready = 1'b0;
        #1 check("bp_gnt", 64'(req_ready), 64'h2);
        tick(); tick();
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_valid", 64'(rsp_valid), 64'h1);
            check("bp_id", 64'(rsp_id), 64'h1);
            check("bp_res", 64'(rsp_res), 64'h202 + 64'(EXP_ERR));
            check("bp_ready", 64'(req_ready), 64'h0);
        end
        rsp_ready = 1'b1;
        tick(); nacc++;
        check("bp_drop", 64'(rsp_valid), 64'h0);
        check("bp_next_gnt", 64'(req_ready), 64'h4);

        // Withdrawn request: no grant, pointer unchanged.
        req_valid = '0;
        #1 check("withdraw_ready", 64'(req_ready), 64'h0);
        tick();
        rsp_ready = 1'b0;
        req_valid = 4'b1000;
        #1 check("withdraw_gnt3", 64'(req_ready), 64'h8);
        tick();
        req_valid = '0;
        tick();
        check("inflight_valid", 64'(rsp_valid), 64'h1);
        check("inflight_id", 64'(rsp_id), 64'h3);

        // Reset during RESP drops the result and clears the pointer.
        rst = 1'b1;
        tick();
        check("midrst_valid", 64'(rsp_valid), 64'h0);
        check("midrst_ready", 64'(req_ready), 64'h0);
        check("midrst_add_in1", 64'(add_in1), 64'h0);
        rst = 1'b0; nacc = 0;
        req_valid = 4'b0110;
        #1 check("midrst_ptr0", 64'(req_ready), 64'h2);

        // Subtract on requester 3: 0x10 - 0x20 mod 2**27.
        set_ops(3, 26'h10, 26'h20, 1'b1);
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        #1 check("sub_gnt", 64'(req_ready), 64'h8);
        tick();
        req_valid = '0;
        check("sub_add_sub", 64'(add_add_sub), 64'h1);
        check("sub_add_in1", 64'(add_in1), 64'h10);
        check("sub_add_in2", 64'(add_in2), 64'h20);
        tick();
        check("sub_valid", 64'(rsp_valid), 64'h1);
        check("sub_id", 64'(rsp_id), 64'h3);
        check("sub_res", 64'(rsp_res), 64'h7FFFFF0 + 64'(EXP_ERR));
        tick(); nacc++;
        check("sub_drop", 64'(rsp_valid), 64'h0);
        check_mon("sub");

        // Further ops on requester 0 to reach counter saturation.
        for (int op = 0; op < 3; op++) begin
            set_ops(0, 26'(op + 7), 26'h1, 1'b0);
            req_valid = 4'b0001;
            #1 check("sat_gnt", 64'(req_ready), 64'h1);
            tick();
            req_valid = '0;
            tick();
            check("sat_res", 64'(rsp_res), 64'(op + 8 + EXP_ERR));
            tick(); nacc++;
            check_mon("sat");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
